fft_frame_scheduler: RTL and testbench

Sequences mic sample history into the FFT processor. Watches the `new_t` strobe and the 16-tap sample history from the mic front end. Every `HOP` new samples it snapshots the 16 taps and streams them oldest-first over a valid/ready port. It then holds off until the FFT reports `fft_done`. Frames that arrive while the FFT is still busy are dropped and flagged.

---
 rtl/fft_frame_scheduler_if.sv | 23 ++
 rtl/fft_frame_scheduler.sv | 73 +++++++
 tb/tb_fft_frame_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if: sample-history input, frame stream and status bundle for the FFT frame scheduler.
interface fft_frame_scheduler_if #(parameter int WIDTH = 18);
  logic             new_t;
  logic [WIDTH-1:0] t [16];
  logic             frame_ready;
  logic             fft_done;
  logic             frame_valid;
  logic [WIDTH-1:0] frame_data;
  logic [3:0]       frame_idx;
  logic             frame_last;
  logic             frame_start;
  logic             busy;
  logic             overrun;
  logic [7:0]       overrun_cnt;
  modport master (
    input  new_t, t, frame_ready, fft_done,
    output frame_valid, frame_data, frame_idx, frame_last, frame_start, busy, overrun, overrun_cnt
  );
  modport slave (
    output new_t, t, frame_ready, fft_done,
    input  frame_valid, frame_data, frame_idx, frame_last, frame_start, busy, overrun, overrun_cnt
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: snapshots the 16-tap history every HOP samples and streams it oldest-first to the FFT.
// FFT_SCHED_OVERRUN_CNT_EN builds the saturating dropped-frame counter; otherwise overrun_cnt is 0.
module fft_frame_scheduler #(
  parameter int HOP   = 8,
  parameter int WIDTH = 18
) (
  input logic clk,
  input logic reset,
  fft_frame_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;
  state_t           r_state, w_state_n;
  logic [4:0]       r_fill, r_hop;
  logic [3:0]       r_idx, w_idx_n;
  logic [WIDTH-1:0] r_snap [16];
  logic [WIDTH-1:0] r_data;
  logic             r_last, r_start, r_overrun;
  logic             w_hop, w_accept, w_xfer;
  // the sample that completes priming also launches the first frame
  assign w_hop    = bus.new_t && (r_fill == 5'd15 || (r_fill == 5'd16 && r_hop == 5'(HOP - 1)));
  assign w_accept = w_hop && (r_state == IDLE || (r_state == WAIT_DONE && bus.fft_done));
  assign w_xfer   = r_state == STREAM && bus.frame_ready;
  assign w_idx_n  = w_xfer ? r_idx + 4'd1 : r_idx;
  always_comb begin
    w_state_n = r_state;
    w_state_n = w_accept ? STREAM :
                (w_xfer && r_idx == 4'hf) ? WAIT_DONE :
                (r_state == WAIT_DONE && bus.fft_done) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_fill    <= '0;
      r_hop     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_start   <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < 16; i++) r_snap[i] <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      if (bus.new_t) begin
        r_fill <= (r_fill == 5'd16) ? r_fill : r_fill + 5'd1;
        r_hop  <= (w_hop || r_fill != 5'd16) ? 5'd0 : r_hop + 5'd1;
      end
      for (int i = 0; i < 16; i++) if (w_accept) r_snap[i] <= bus.t[15 - i];
      // on acceptance the snapshot is still in flight, so index 0 comes straight from the oldest tap
      r_data    <= (w_state_n != STREAM) ? '0 : w_accept ? bus.t[15] : r_snap[w_idx_n];
      r_last    <= w_state_n == STREAM && w_idx_n == 4'hf;
      r_start   <= w_accept;
      r_overrun <= w_hop && !w_accept;
    end
  end
`ifdef FFT_SCHED_OVERRUN_CNT_EN
  logic [7:0] r_ocnt;
  always_ff @(posedge clk) begin
    if (!reset) r_ocnt <= '0;
    else if (w_hop && !w_accept && r_ocnt != 8'hff) r_ocnt <= r_ocnt + 8'd1;
  end
  assign bus.overrun_cnt = r_ocnt;
`else
  assign bus.overrun_cnt = '0;
`endif
  assign bus.frame_valid = r_state == STREAM;
  assign bus.busy        = r_state != IDLE;
  assign bus.frame_data  = r_data;
  assign bus.frame_idx   = r_idx;
  assign bus.frame_last  = r_last;
  assign bus.frame_start = r_start;
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: directed/randomized bench with a sample-count reference model for HOP=8 and HOP=1 builds.
module tb_fft_frame_scheduler;
  logic clk = 0, reset = 0, new_t = 0, frame_ready = 0, fft_done = 0;
  logic [17:0] hist [16];
  bit sel = 0;
  int checks = 0, failures = 0;
  int n = 0, drops = 0, hop_m = 8;
  bit m_busy = 0;
  logic [17:0] exp_f [16];

  fft_frame_scheduler_if #(.WIDTH(18)) b1 ();
  fft_frame_scheduler_if #(.WIDTH(18)) b2 ();
  fft_frame_scheduler #(.HOP(8), .WIDTH(18)) dut  (.clk(clk), .reset(reset), .bus(b1.master));
  fft_frame_scheduler #(.HOP(1), .WIDTH(18)) dut1 (.clk(clk), .reset(reset), .bus(b2.master));

  assign b1.new_t = new_t;        assign b2.new_t = new_t;
  assign b1.frame_ready = frame_ready; assign b2.frame_ready = frame_ready;
  assign b1.fft_done = fft_done;  assign b2.fft_done = fft_done;
  for (genvar g = 0; g < 16; g++) begin : g_taps
    assign b1.t[g] = hist[g];
    assign b2.t[g] = hist[g];
  end

  logic o_valid, o_last, o_start, o_busy, o_overrun;
  logic [17:0] o_data;
  logic [3:0] o_idx;
  logic [7:0] o_ocnt;
  assign o_valid   = sel ? b2.frame_valid : b1.frame_valid;
  assign o_last    = sel ? b2.frame_last  : b1.frame_last;
  assign o_start   = sel ? b2.frame_start : b1.frame_start;
  assign o_busy    = sel ? b2.busy        : b1.busy;
  assign o_overrun = sel ? b2.overrun     : b1.overrun;
  assign o_data    = sel ? b2.frame_data  : b1.frame_data;
  assign o_idx     = sel ? b2.frame_idx   : b1.frame_idx;
  assign o_ocnt    = sel ? b2.overrun_cnt : b1.overrun_cnt;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_ocnt();
`ifdef FFT_SCHED_OVERRUN_CNT_EN
    return (drops > 255) ? 32'd255 : 32'(drops);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_data"}, 32'(o_data), 0);
    chk({tag, "_idx"}, 32'(o_idx), 0);
    chk({tag, "_last"}, 32'(o_last), 0);
    chk({tag, "_start"}, 32'(o_start), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_overrun"}, 32'(o_overrun), 0);
    chk({tag, "_ocnt"}, 32'(o_ocnt), 0);
  endtask

  task automatic model_reset();
    n = 0; drops = 0; m_busy = 0;
  endtask

  // one new sample; val < 0 picks a random sample
  task automatic push(input bit done_now, input int val, output bit acc);
    bit hop;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = (val < 0) ? 18'($urandom) : 18'(val);
    n++;
    hop = (n == 16) || (n > 16 && (n - 16) % hop_m == 0);
    acc = hop && (!m_busy || done_now);
    if (done_now) m_busy = 0;
    if (acc) begin
      m_busy = 1;
      for (int i = 0; i < 16; i++) exp_f[i] = hist[15 - i];
    end
    if (hop && !acc) drops++;
    new_t = 1;
    fft_done = done_now;
    tick();
    new_t = 0;
    fft_done = 0;
    chk("frame_start", 32'(o_start), 32'(acc));
    chk("overrun", 32'(o_overrun), 32'(hop && !acc));
    chk("overrun_cnt", 32'(o_ocnt), exp_ocnt());
  endtask

  task automatic pushes(input int cnt);
    bit a;
    for (int k = 0; k < cnt; k++) push(0, -1, a);
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random; stop_at >= 0 returns at that index
  task automatic stream(input int mode, input int stop_at);
    int e = 0, cyc = 0;
    bit pat [4] = '{1, 0, 0, 1};
    while (e < 16 && cyc < 200) begin
      if (e == stop_at) return;
      chk("stream_valid", 32'(o_valid), 1);
      chk("stream_idx", 32'(o_idx), 32'(e));
      chk("stream_data", 32'(o_data), 32'(exp_f[e]));
      chk("stream_last", 32'(o_last), 32'(e == 15));
      frame_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom);
      tick();
      if (frame_ready) e++;
      cyc++;
    end
    frame_ready = 0;
    chk("stream_complete", 32'(e), 16);
    chk("post_stream_valid", 32'(o_valid), 0);
    chk("post_stream_busy", 32'(o_busy), 1);
    chk("post_stream_data", 32'(o_data), 0);
  endtask

  task automatic done();
    fft_done = 1;
    m_busy = 0;
    tick();
    fft_done = 0;
    chk("done_busy", 32'(o_busy), 0);
  endtask

  initial begin
    bit a;
    int frames;
    for (int i = 0; i < 16; i++) hist[i] = '0;
    repeat (3) tick();
    chk_reset("reset");
    reset = 1;
    // priming: taps end up as tK = K+1, frame must read 16..1
    frame_ready = 1;
    for (int j = 0; j < 16; j++) push(0, 16 - j, a);
    chk("prime_first_word", 32'(o_data), 16);
    stream(0, -1);
    done();
    // backpressure
    pushes(8);
    stream(1, -1);
    done();
    // random ready, then withhold fft_done across two hop events
    pushes(8);
    stream(2, -1);
    pushes(16);
    chk("overrun_busy", 32'(o_busy), 1);
    chk("overrun_valid", 32'(o_valid), 0);
    // hop event coinciding with fft_done
    pushes(7);
    push(1, -1, a);
    stream(0, -1);
    done();
    // reset mid-stream at index 5
    pushes(8);
    stream(0, 5);
    chk("pre_reset_idx", 32'(o_idx), 5);
    reset = 0;
    tick();
    chk_reset("midreset");
    model_reset();
    reset = 1;
    frame_ready = 1;
    pushes(15);
    frame_ready = 0;
    push(0, -1, a);
    stream(2, -1);
    done();
    // HOP = 1 instance
    sel = 1;
    hop_m = 1;
    reset = 0;
    tick();
    chk_reset("hop1_reset");
    model_reset();
    reset = 1;
    frames = 0;
    for (int k = 0; k < 20; k++) begin
      push(0, -1, a);
      if (a) begin
        frames++;
        stream(0, -1);
        repeat (4) tick();
        done();
        repeat (17) tick();
      end else repeat (39) tick();
    end
    chk("hop1_frames", 32'(frames), 5);
    chk("hop1_overruns", 32'(drops), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
